// File: rtl/boton_pulsos.sv
// Button front end: 2-flop sync + debounce per button, UP/down step pulses and TC/LP target FSM.
// Define BOTON_AUTOREPEAT_EN to build the hold-to-repeat logic for the step buttons.
module boton_pulsos #(
  parameter int DEB_CYCLES    = 16,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic Clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_mode,
  output logic UP,
  output logic down,
  output logic TC,
  output logic LP
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam int B_UP   = 0;
  localparam int B_DOWN = 1;
  localparam int B_MODE = 2;

  typedef enum logic [1:0] {
    TONO     = 2'd0,
    LETRAS   = 2'd1,
    PANTALLA = 2'd2
  } target_e;

  logic [2:0]    raw;
  logic [2:0]    s1_q, s2_q;
  logic [2:0]    d_q, d_d;
  logic [2:0]    rise;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [1:0]    fire;
  logic          up_q, up_d;
  logic          down_q, down_d;
  target_e       state_q, state_d;

  assign raw = {btn_mode, btn_down, btn_up};

  // Debounce: the level flips on the edge the mismatch run would reach DEB_CYCLES.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      d_d[i]   = d_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != d_q[i]) begin
        if (cnt_q[i] == DEB_LAST) d_d[i] = s2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Press events are taken from the next level so pulses and FSM move on the same edge as d.
  assign rise = d_d & ~d_q;

  always_ff @(posedge Clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      d_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      d_q  <= d_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef BOTON_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_PERIOD = RW'(REPEAT_PERIOD);

  // Down-counter per step button; zero means repeat is idle until the next press event.
  logic [RW-1:0] rpt_q [2];
  logic [RW-1:0] rpt_d [2];

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      rpt_d[j] = '0;
      fire[j]  = 1'b0;
      if (rise[j]) begin
        rpt_d[j] = d_d[1-j] ? '0 : RPT_DELAY;
      end else if (rpt_q[j] != '0 && d_d[j] && !d_d[1-j]) begin
        if (rpt_q[j] == RW'(1)) begin
          fire[j]  = 1'b1;
          rpt_d[j] = RPT_PERIOD;
        end else begin
          rpt_d[j] = rpt_q[j] - RW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      rpt_q[0] <= '0;
      rpt_q[1] <= '0;
    end else begin
      rpt_q[0] <= rpt_d[0];
      rpt_q[1] <= rpt_d[1];
    end
  end
`else
  assign fire = 2'b00;
`endif

  // UP wins a same-cycle collision so the two pulses are mutually exclusive.
  always_comb begin
    up_d   = rise[B_UP] | fire[B_UP];
    down_d = (rise[B_DOWN] | fire[B_DOWN]) & ~up_d;
  end

  always_comb begin
    state_d = state_q;
    if (rise[B_MODE]) begin
      case (state_q)
        TONO:     state_d = LETRAS;
        LETRAS:   state_d = PANTALLA;
        PANTALLA: state_d = TONO;
        default:  state_d = TONO;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      state_q <= TONO;
    end else begin
      up_q    <= up_d;
      down_q  <= down_d;
      state_q <= state_d;
    end
  end

  assign UP   = up_q;
  assign down = down_q;
  assign TC   = (state_q == TONO);
  assign LP   = (state_q == LETRAS);

endmodule

// File: tb/tb_boton_pulsos.sv
// Bench for boton_pulsos: window-based debounce model checked every cycle, plus literal timing checks.
module tb_boton_pulsos;

  localparam int DEB = 4;
  localparam int DLY = 20;
  localparam int PER = 8;

  logic Clk, reset, btn_up, btn_down, btn_mode;
  logic UP, down, TC, LP;

  boton_pulsos #(.DEB_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
    .Clk(Clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_mode(btn_mode),
    .UP(UP), .down(down), .TC(TC), .LP(LP)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp_v, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Model: a button level flips once DEB consecutive synchronised samples disagree with it.
  int unsigned       cyc = 0;
  logic [DEB+1:0]    hist [3];
  logic [2:0]        dm, nd, rise, rawv;
  logic [1:0]        fire;
  bit                rpt_on [2];
  int unsigned       press_at [2];
  int unsigned       age;
  int                mode_idx;
  logic              exp_up, exp_down;
  bit                model_ok = 0;
  bit                all_diff;

  always @(posedge Clk) begin
    cyc++;
    if (reset) begin
      for (int b = 0; b < 3; b++) hist[b] = '0;
      dm = '0;
      rpt_on[0] = 0;
      rpt_on[1] = 0;
      mode_idx = 0;
      exp_up = 0;
      exp_down = 0;
      model_ok = 1;
    end else begin
      rawv = {btn_mode, btn_down, btn_up};
      for (int b = 0; b < 3; b++) begin
        hist[b] = {hist[b][DEB:0], rawv[b]};
        all_diff = 1;
        for (int k = 2; k <= DEB + 1; k++)
          if (hist[b][k] == dm[b]) all_diff = 0;
        nd[b] = all_diff ? ~dm[b] : dm[b];
      end
      rise = nd & ~dm;
      fire = 2'b00;
      for (int j = 0; j < 2; j++) begin
        if (rise[j]) begin
          rpt_on[j] = !nd[1-j];
          press_at[j] = cyc;
        end else if (rpt_on[j]) begin
          if (!nd[j] || nd[1-j]) rpt_on[j] = 0;
          else begin
            age = cyc - press_at[j];
`ifdef BOTON_AUTOREPEAT_EN
            if (age >= DLY && (age - DLY) % PER == 0) fire[j] = 1'b1;
`endif
          end
        end
      end
      exp_up   = rise[0] | fire[0];
      exp_down = (rise[1] | fire[1]) & ~exp_up;
      if (rise[2]) mode_idx = (mode_idx + 1) % 3;
      dm = nd;
    end
  end

  // Compare process: full output vector every cycle, and log pulse times
  int unsigned up_times[$];
  int unsigned down_times[$];

  always @(negedge Clk) begin
    if (model_ok) begin
      chk("outputs", {28'd0, UP, down, TC, LP},
          {28'd0, exp_up, exp_down, (mode_idx == 0), (mode_idx == 1)});
      if (UP === 1'b1)   up_times.push_back(cyc);
      if (down === 1'b1) down_times.push_back(cyc);
    end
  end

  int unsigned t, p;
  int n_exp;
  logic [1:0] mode_tab [3];
  logic [6:0] pat;

  initial begin
    reset = 1'b1; btn_up = 0; btn_down = 0; btn_mode = 0;
    mode_tab[0] = 2'b01; mode_tab[1] = 2'b00; mode_tab[2] = 2'b10;
    pat = 7'b1110110;
    tick(2);
    chk("reset_vals", {28'd0, UP, down, TC, LP}, 32'h2);
    reset = 1'b0;
    tick(2);

    // 1: clean press
    up_times.delete(); down_times.delete();
    t = cyc; btn_up = 1;
    tick(10);
    btn_up = 0;
    tick(10);
    chk("s1_up_count", up_times.size(), 1);
    if (up_times.size() > 0) chk("s1_up_time", up_times[0], t + 6);
    chk("s1_down_count", down_times.size(), 0);
    chk("s1_tc_lp", {30'd0, TC, LP}, 32'h2);

    // 2: bounce rejection
    up_times.delete(); down_times.delete();
    for (int i = 6; i >= 0; i--) begin
      btn_down = pat[i];
      tick(1);
    end
    chk("s2_no_bounce_pulse", down_times.size(), 0);
    t = cyc; btn_down = 1;
    tick(10);
    btn_down = 0;
    tick(10);
    chk("s2_down_count", down_times.size(), 1);
    if (down_times.size() > 0) chk("s2_down_time", down_times[0], t + 6);

    // 3: mode cycling
    up_times.delete(); down_times.delete();
    for (int i = 0; i < 3; i++) begin
      btn_mode = 1;
      tick(6);
      btn_mode = 0;
      tick(6);
      chk("s3_tc_lp", {30'd0, TC, LP}, {30'd0, mode_tab[i]});
    end
    chk("s3_no_steps", up_times.size() + down_times.size(), 0);

    // 4/5: held up button, repeat only when compiled in
    up_times.delete(); down_times.delete();
    t = cyc; p = t + 6; btn_up = 1;
    tick(59);
    btn_up = 0;
    tick(20);
`ifdef BOTON_AUTOREPEAT_EN
    n_exp = 6;
`else
    n_exp = 1;
`endif
    chk("s4_up_count", up_times.size(), n_exp);
    for (int i = 0; i < n_exp && i < up_times.size(); i++)
      chk("s4_up_time", up_times[i], (i == 0) ? p : p + DLY + PER * (i - 1));

    // 6: simultaneous press, then reset while held
    up_times.delete(); down_times.delete();
    t = cyc; btn_up = 1; btn_down = 1;
    tick(30);
    chk("s6_up_count", up_times.size(), 1);
    if (up_times.size() > 0) chk("s6_up_time", up_times[0], t + 6);
    chk("s6_down_count", down_times.size(), 0);
    btn_down = 0;
    tick(8);
    reset = 1;
    tick(2);
    chk("s6_reset_vals", {28'd0, UP, down, TC, LP}, 32'h2);
    reset = 0;
    t = cyc;
    up_times.delete(); down_times.delete();
    tick(10);
    chk("s6_post_reset_count", up_times.size(), 1);
    if (up_times.size() > 0) chk("s6_post_reset_time", up_times[0], t + 6);
    btn_up = 0;
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
